serial_add_ctrl: RTL

Sequencer and bit-serial arithmetic core for the serial adder. It drives the load and shift-enable inputs of the two operand shift registers (`shift_r` instances A and B). It consumes their one-bit-per-cycle outputs, adds them LSB-first through a carry flip-flop, and assembles the WIDTH-bit sum. A start/busy/done handshake connects it to the host.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/serial_add_ctrl_if.sv | 14 +
 rtl/serial_add_acc.sv | 25 ++
 rtl/shift_r.sv | 22 ++
 rtl/serial_add_ctrl.sv | 77 +++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encoding and sizing helpers shared by the serial adder files
package serial_add_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: host handshake, operand bit streams and result bundle of the serial adder
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start_i;
    logic             a_bit_i;
    logic             b_bit_i;
    logic             load_o;
    logic             shift_en_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    modport master (output start_i, a_bit_i, b_bit_i, input load_o, shift_en_o, busy_o, done_o, sum_o, cout_o);
    modport slave  (input start_i, a_bit_i, b_bit_i, output load_o, shift_en_o, busy_o, done_o, sum_o, cout_o);
endinterface

// File: rtl/serial_add_acc.sv
// serial_add_acc: carry flop, full adder and LSB-first sum accumulator
module serial_add_acc #(parameter int WIDTH = 8) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add_en,
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] acc,
    output logic             carry
);
    // each add shifts the new sum bit in at the top, so after WIDTH adds bit 0 sits at acc[0]
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (add_en) begin
            acc   <= {a ^ b ^ carry, acc[WIDTH-1:1]};
            carry <= (a & b) | (a & carry) | (b & carry);
        end
    end
endmodule

// File: rtl/shift_r.sv
// shift_r: parallel-load operand register emitting one registered bit per shift, LSB first
module shift_r #(parameter int WIDTH = 8) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             data_o
);
    logic [WIDTH-1:0] r_q;
    // load the operand, then move its LSB into the output flop on every shift
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            data_o <= 1'b0;
        end else if (load_i) begin
            r_q <= data_i;
        end else if (shift_en_i) begin
            {r_q, data_o} <= {1'b0, r_q};
        end
    end
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequencer for the operand registers and bit-serial adder with start/busy/done handshake
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_n,
    serial_add_ctrl_if.slave    bus
);
    localparam int CW = cnt_w(WIDTH);
    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_add_en;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [WIDTH-1:0] w_acc;
    logic             w_carry;
    logic             w_clr;
    logic             w_last;
    assign w_clr  = (r_state == LOAD);
    assign w_last = (r_cnt == CW'(WIDTH - 1));
    // state register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // next state and Moore strobes; DRAIN waits until the delayed add enable has retired the last bit
    always_comb begin
        w_next         = r_state;
        bus.load_o     = (r_state == LOAD);
        bus.shift_en_o = (r_state == SHIFT);
        bus.busy_o     = (r_state != IDLE);
        bus.done_o     = (r_state == DONE);
        case (r_state)
            IDLE:    w_next = bus.start_i ? LOAD : IDLE;
            LOAD:    w_next = SHIFT;
            SHIFT:   w_next = w_last ? DRAIN : SHIFT;
            DRAIN:   w_next = r_add_en ? DRAIN : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // bit counter runs only in SHIFT; add enable lags shift enable to match the registered operand bits
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_add_en <= 1'b0;
        end else begin
            r_cnt    <= (r_state == SHIFT) ? r_cnt + 1'b1 : '0;
            r_add_en <= bus.shift_en_o;
        end
    end
    // capture the finished result on entry to DONE and hold it until the next one
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (r_state == DRAIN && !r_add_en) begin
            r_sum  <= w_acc;
            r_cout <= w_carry;
        end
    end
    assign bus.sum_o  = r_sum;
    assign bus.cout_o = r_cout;
    serial_add_acc #(.WIDTH(WIDTH)) u_acc (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .add_en (r_add_en),
        .a      (bus.a_bit_i),
        .b      (bus.b_bit_i),
        .acc    (w_acc),
        .carry  (w_carry)
    );
endmodule
